axis_tag_reorder: RTL and testbench
===================================

Name: axis_tag_reorder

Overview:
Receives the tagged, possibly out-of-order packet stream that the packet filter emits on its forwarder (cb_*) interface. Each packet is buffered in a per-tag slot, and packets are re-emitted as a plain AXI stream in strictly ascending tag order (mod 2^TAG_WIDTH). A drop-notification port lets the filter mark tags whose packets were rejected, so the in-order pointer can skip them. The block sits directly downstream of axistream_packetfilt.

Parameters:
DATA_WIDTH, 64, TDATA width in bits; KEEP_WIDTH = DATA_WIDTH/8
TAG_WIDTH, 6, reorder tag width; SLOTS = 2^TAG_WIDTH
MAX_BEATS, 256, max beats stored per packet (2048 B at 64 bits)
BEAT_W, derived, CLOG2(MAX_BEATS)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
cb_TDATA  in  DATA_WIDTH  input beat data
cb_TKEEP  in  KEEP_WIDTH  input byte enables
cb_TLAST  in  1  input last beat
cb_TVALID  in  1  input valid
cb_TREADY  out  1  input ready
cb_reorder_tag  in  TAG_WIDTH  packet tag; sampled on first beat only
drop_valid  in  1  single-cycle pulse: tag drop_tag will never arrive
drop_tag  in  TAG_WIDTH  tag of dropped packet
out_TDATA  out  DATA_WIDTH  output beat data
out_TKEEP  out  KEEP_WIDTH  output byte enables
out_TLAST  out  1  output last beat
out_TVALID  out  1  output valid
out_TREADY  in  1  output ready
expected_tag  out  TAG_WIDTH  next tag to emit
err_drop_collision  out  1  pulse: drop targeted a non-EMPTY slot
err_oversize  out  1  pulse: packet exceeded MAX_BEATS and was truncated
num_packets_out  out  16  emitted packet count, wraps at 2^16

Behaviour:
- Reset (async): all slots EMPTY, expected_tag=0, cb_TREADY=0, out_TVALID=0, out_TDATA/TKEEP/TLAST=0, error pulses 0, num_packets_out=0. On reset release, cb_TREADY rises on the first clk edge.
- Slot state: 2 bits per slot: EMPTY, FILLING, READY, SKIP. Per-slot length register: BEAT_W+1 bits.
- Data RAM: SLOTS*MAX_BEATS words of {TDATA,TKEEP}. One synchronous write port, one synchronous read port; read latency 1.
- Write side, first beat (start of packet): tag = cb_reorder_tag.
  - If slot[tag] != EMPTY: cb_TREADY=0 (window full). Stall until the slot is EMPTY.
  - Otherwise accept the beat, latch tag, set the slot to FILLING and write address tag*MAX_BEATS+0.
- Write side, later beats: cb_TREADY=1 and the write address increments.
- Oversize: beats past MAX_BEATS are accepted and discarded. On TLAST, pulse err_oversize and record length=MAX_BEATS.
- End of packet: on the TLAST handshake, record the length and set the slot to READY the next cycle.
- Drop: if slot[drop_tag]==EMPTY, set it to SKIP. Otherwise ignore the drop and pulse err_drop_collision.
  - Same cycle and same tag as an accepted first beat: the packet wins and the drop is flagged as a collision.
- Read FSM states:
  - IDLE:
    - If slot[expected_tag]==READY, issue a read of beat 0 and go to LOAD.
    - If SKIP, set the slot EMPTY, increment expected_tag, stay in IDLE (one tag per cycle).
    - If EMPTY or FILLING, wait.
  - LOAD: the RAM output is registered into out_*, out_TVALID=1, go to SEND.
  - SEND, on the out handshake:
    - Not the last beat: the read address for the next beat is issued the same cycle, so out_* updates next cycle with no bubble (1 beat/cycle).
    - Last beat (beat==length-1): out_TLAST was asserted with it. Set the slot EMPTY, increment expected_tag mod SLOTS and num_packets_out, clear out_TVALID, go to IDLE.
- out_* hold stable while out_TVALID && !out_TREADY (AXI rule).
- A slot freed by the read side becomes writable on the following cycle; a same-cycle new start is not accepted.
- expected_tag wrap: SLOTS-1 -> 0.
- Reset mid-packet: all in-flight data is discarded and the filter must also be reset.

Decomposition:
- Shared package: slot-state encodings (EMPTY=0, FILLING=1, READY=2, SKIP=3), read-FSM state encodings, CLOG2 macro.
- Sub-module reorder_slot_ram: simple dual-port synchronous RAM, parameterised depth and width, inferred as BRAM.

Test Plan:
1. Tags 1, 0, 2 arrive, 3 beats each, out_TREADY=1 -> output order 0, 1, 2; TLAST on every 3rd beat; num_packets_out=3; expected_tag=3.
2. drop_valid with tag 0, then packet tag 1 (2 beats) -> slot 0 skipped; packet 1 emitted; expected_tag=2; no error.
3. Packet tag 5 held READY (expected_tag=5, out_TREADY=0), then a new packet with tag 5 -> cb_TREADY=0. Raise out_TREADY -> slot drained, then the new packet is accepted.
4. 300-beat packet, tag 0 -> err_oversize pulse; 256 beats output; TLAST on beat 256.
5. drop_tag=3 while slot 3 is FILLING -> err_drop_collision=1 for 1 cycle; the packet is still emitted in order.
6. rst asserted mid-SEND -> out_TVALID=0 immediately; expected_tag=0; all slots EMPTY; tag 0 accepted after release.

Source files
------------

// File: rtl/axis_tag_reorder_pkg.sv
// axis_tag_reorder_pkg: slot/read-FSM encodings and width helper for the tag reorder buffer
package axis_tag_reorder_pkg;
  typedef enum logic [1:0] {S_EMPTY = 2'd0, S_FILLING = 2'd1, S_READY = 2'd2, S_SKIP = 2'd3} slot_t;
  typedef enum logic [1:0] {R_IDLE = 2'd0, R_LOAD = 2'd1, R_SEND = 2'd2} rd_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/reorder_slot_ram.sv
// reorder_slot_ram: simple dual-port synchronous RAM, read data held while re is low
module reorder_slot_ram
  import axis_tag_reorder_pkg::*;
#(
  parameter int DEPTH = 16384,
  parameter int WIDTH = 72,
  parameter int AW = clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end
endmodule

// File: rtl/axis_tag_reorder.sv
// axis_tag_reorder: buffers tagged packets per slot and re-emits them in ascending tag order
module axis_tag_reorder
  import axis_tag_reorder_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int TAG_WIDTH = 6,
  parameter int MAX_BEATS = 256,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] cb_TDATA,
  input  logic [KEEP_WIDTH-1:0] cb_TKEEP,
  input  logic                  cb_TLAST,
  input  logic                  cb_TVALID,
  output logic                  cb_TREADY,
  input  logic [TAG_WIDTH-1:0]  cb_reorder_tag,
  input  logic                  drop_valid,
  input  logic [TAG_WIDTH-1:0]  drop_tag,
  output logic [DATA_WIDTH-1:0] out_TDATA,
  output logic [KEEP_WIDTH-1:0] out_TKEEP,
  output logic                  out_TLAST,
  output logic                  out_TVALID,
  input  logic                  out_TREADY,
  output logic [TAG_WIDTH-1:0]  expected_tag,
  output logic                  err_drop_collision,
  output logic                  err_oversize,
  output logic [15:0]           num_packets_out
);
  localparam int SLOTS = 2 ** TAG_WIDTH;
  localparam int BEAT_W = clog2(MAX_BEATS);
  localparam int W = DATA_WIDTH + KEEP_WIDTH;
  localparam logic [BEAT_W:0] MAXB = (BEAT_W + 1)'(MAX_BEATS);
  localparam logic [BEAT_W:0] ONE = (BEAT_W + 1)'(1);
  slot_t slot_st [SLOTS];
  logic [BEAT_W:0] slot_len [SLOTS];
  logic run, in_pkt;
  logic [TAG_WIDTH-1:0] wtag, cur_tag;
  logic [BEAT_W:0] wcnt, rptr, cur_cnt, cur_len;
  logic acc, sop, over, we, re, hs, rd_go, skip_go, last_hs, drop_bad, drop_ok;
  logic [W-1:0] q;
  rd_t st, st_nx;
  always_comb begin
    cur_tag = in_pkt ? wtag : cb_reorder_tag;
    cur_cnt = in_pkt ? wcnt : '0;
    cb_TREADY = run && (in_pkt || slot_st[cb_reorder_tag] == S_EMPTY);
    acc = cb_TVALID && cb_TREADY;
    sop = acc && !in_pkt;
    over = cur_cnt >= MAXB;
    we = acc && !over;
    cur_len = slot_len[expected_tag];
    hs = out_TVALID && out_TREADY;
    last_hs = st == R_SEND && hs && out_TLAST;
    rd_go = st == R_IDLE && slot_st[expected_tag] == S_READY;
    skip_go = st == R_IDLE && slot_st[expected_tag] == S_SKIP;
    re = rd_go || st == R_LOAD || (st == R_SEND && hs);
    drop_bad = drop_valid && (slot_st[drop_tag] != S_EMPTY || (sop && cb_reorder_tag == drop_tag));
    drop_ok = drop_valid && !drop_bad;
    st_nx = rd_go ? R_LOAD : st == R_LOAD ? R_SEND : last_hs ? R_IDLE : st;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) st <= R_IDLE;
    else st <= st_nx;
  // Write side and both read-side frees update disjoint slots, so plain ordering suffices
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) slot_st[i] <= S_EMPTY;
      run <= 1'b0;
      in_pkt <= 1'b0;
      wtag <= '0;
      wcnt <= '0;
      err_oversize <= 1'b0;
      err_drop_collision <= 1'b0;
    end else begin
      run <= 1'b1;
      err_oversize <= acc && cb_TLAST && over;
      err_drop_collision <= drop_bad;
      if (drop_ok) slot_st[drop_tag] <= S_SKIP;
      if (skip_go || last_hs) slot_st[expected_tag] <= S_EMPTY;
      if (acc) begin
        wtag <= cur_tag;
        in_pkt <= !cb_TLAST;
        wcnt <= over ? MAXB : cur_cnt + ONE;
        slot_st[cur_tag] <= cb_TLAST ? S_READY : S_FILLING;
      end
    end
  always_ff @(posedge clk)
    if (acc && cb_TLAST) slot_len[cur_tag] <= over ? MAXB : cur_cnt + ONE;
  // rptr runs one beat ahead of out_*, so the RAM always holds the next beat ready
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      expected_tag <= '0;
      num_packets_out <= '0;
      rptr <= '0;
      out_TDATA <= '0;
      out_TKEEP <= '0;
      out_TLAST <= 1'b0;
      out_TVALID <= 1'b0;
    end else begin
      if (skip_go || last_hs) expected_tag <= expected_tag + TAG_WIDTH'(1);
      if (last_hs) begin
        num_packets_out <= num_packets_out + 16'd1;
        out_TVALID <= 1'b0;
        rptr <= '0;
      end else if (rd_go) rptr <= ONE;
      else if (st == R_LOAD || (st == R_SEND && hs)) begin
        {out_TDATA, out_TKEEP} <= q;
        out_TLAST <= rptr == cur_len;
        out_TVALID <= 1'b1;
        rptr <= rptr + ONE;
      end
    end
  reorder_slot_ram #(.DEPTH(SLOTS * MAX_BEATS), .WIDTH(W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr ({cur_tag, cur_cnt[BEAT_W-1:0]}),
    .wdata ({cb_TDATA, cb_TKEEP}),
    .re    (re),
    .raddr ({expected_tag, rptr[BEAT_W-1:0]}),
    .rdata (q)
  );
endmodule

// File: tb/tb_axis_tag_reorder.sv
// tb_axis_tag_reorder: randomized packets against a per-tag queue model of in-order release
module tb_axis_tag_reorder;
  logic clk = 0, rst = 1;
  logic [63:0] cb_TDATA = '0;
  logic [7:0] cb_TKEEP = '0;
  logic cb_TLAST = 0, cb_TVALID = 0, cb_TREADY;
  logic [5:0] cb_reorder_tag = '0;
  logic drop_valid = 0;
  logic [5:0] drop_tag = '0;
  logic [63:0] out_TDATA;
  logic [7:0] out_TKEEP;
  logic out_TLAST, out_TVALID;
  logic out_TREADY = 0;
  logic [5:0] expected_tag;
  logic err_drop_collision, err_oversize;
  logic [15:0] num_packets_out;
  int rdy_mode = 1;
  int n_cmp = 0, n_bad = 0, mon_pkts = 0, ov_n = 0, dc_n = 0, mexp = 0, pk_base = 0;
  logic [71:0] mq [64][$];
  int lenq [64][$];
  bit dropped [64];
  logic [71:0] cur [$];

  axis_tag_reorder dut (
    .clk(clk), .rst(rst),
    .cb_TDATA(cb_TDATA), .cb_TKEEP(cb_TKEEP), .cb_TLAST(cb_TLAST), .cb_TVALID(cb_TVALID),
    .cb_TREADY(cb_TREADY), .cb_reorder_tag(cb_reorder_tag),
    .drop_valid(drop_valid), .drop_tag(drop_tag),
    .out_TDATA(out_TDATA), .out_TKEEP(out_TKEEP), .out_TLAST(out_TLAST), .out_TVALID(out_TVALID),
    .out_TREADY(out_TREADY), .expected_tag(expected_tag),
    .err_drop_collision(err_drop_collision), .err_oversize(err_oversize),
    .num_packets_out(num_packets_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #2;
    out_TREADY = rdy_mode == 2 ? ($urandom_range(0, 3) != 0) : (rdy_mode == 1);
  end

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    for (int k = 0; k < 64 && dropped[mexp]; k++) begin
      dropped[mexp] = 0;
      mexp = (mexp + 1) % 64;
    end
  endtask

  task automatic finish_pkt();
    int n;
    logic [71:0] b;
    settle();
    if (lenq[mexp].size() == 0) chk("pkt_known", 0, 1);
    else begin
      n = lenq[mexp].pop_front();
      chk("pkt_len", cur.size(), n);
      for (int i = 0; i < n; i++) begin
        b = mq[mexp].pop_front();
        if (i < cur.size()) chk("beat", cur[i], b);
      end
    end
    cur.delete();
    mexp = (mexp + 1) % 64;
    mon_pkts++;
  endtask

  always @(negedge clk) begin
    if (err_oversize) ov_n++;
    if (err_drop_collision) dc_n++;
    if (rst) cur.delete();
    else if (out_TVALID && out_TREADY) begin
      cur.push_back({out_TDATA, out_TKEEP});
      if (out_TLAST) finish_pkt();
    end
  end

  task automatic send_pkt(input int tag, input int n, input bit gaps);
    logic [71:0] b;
    int to;
    lenq[tag].push_back(n > 256 ? 256 : n);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        cb_TVALID = 0;
        step();
      end
      b = {$urandom, $urandom, 8'($urandom)};
      if (i < 256) mq[tag].push_back(b);
      {cb_TDATA, cb_TKEEP} = b;
      cb_TLAST = i == n - 1;
      cb_reorder_tag = i == 0 ? 6'(tag) : 6'($urandom);
      cb_TVALID = 1;
      to = 0;
      do begin
        @(negedge clk);
        to++;
      end while (!cb_TREADY && to < 3000);
      if (!cb_TREADY) begin
        chk("tready_timeout", 0, 1);
        cb_TVALID = 0;
        return;
      end
      step();
    end
    cb_TVALID = 0;
    cb_TLAST = 0;
  endtask

  task automatic drop(input int t, input bit ok);
    drop_valid = 1;
    drop_tag = 6'(t);
    if (ok) dropped[t] = 1;
    step();
    drop_valid = 0;
  endtask

  task automatic wait_pkts(input int n);
    for (int k = 0; k < 5000 && mon_pkts < n; k++) step();
    chk("drain", mon_pkts, n);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int base, n, t, j, tmp, target;
    int tg [$];
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tready", cb_TREADY, 0);
    chk("rst_tvalid", out_TVALID, 0);
    chk("rst_tdata", out_TDATA, 0);
    chk("rst_exp", expected_tag, 0);
    chk("rst_npk", num_packets_out, 0);
    rst = 0;
    chk("rel_tready0", cb_TREADY, 0);
    step();
    chk("rel_tready1", cb_TREADY, 1);

    send_pkt(1, 3, 0);
    send_pkt(0, 3, 0);
    send_pkt(2, 3, 0);
    wait_pkts(3);
    step();
    chk("p1_npk", num_packets_out, 3);
    chk("p1_exp", expected_tag, 3);

    drop(3, 1);
    send_pkt(4, 2, 1);
    wait_pkts(4);
    step();
    settle();
    chk("p2_exp", expected_tag, mexp);
    chk("p2_err", dc_n, 0);

    rdy_mode = 0;
    send_pkt(5, 2, 0);
    repeat (6) step();
    chk("hold_valid", out_TVALID, 1);
    chk("hold_data", {out_TDATA, out_TKEEP}, mq[5][0]);
    fork
      send_pkt(5, 3, 0);
      begin
        repeat (6) step();
        chk("win_full", cb_TREADY, 0);
        rdy_mode = 1;
      end
    join
    chk("p3_first", mon_pkts, 5);
    for (int k = 6; k < 69; k++) drop(k % 64, 1);
    wait_pkts(6);
    step();
    settle();
    chk("p3_exp", expected_tag, mexp);

    send_pkt(6, 300, 0);
    wait_pkts(7);
    step();
    chk("p4_oversize", ov_n, 1);
    chk("p4_exp", expected_tag, 7);

    fork
      send_pkt(8, 20, 0);
      begin
        repeat (5) step();
        drop(8, 0);
      end
    join
    send_pkt(7, 2, 1);
    wait_pkts(9);
    step();
    chk("p5_collision", dc_n, 1);
    chk("p5_exp", expected_tag, 9);

    for (int r = 0; r < 20; r++) begin
      settle();
      base = mexp;
      n = $urandom_range(1, 8);
      tg.delete();
      rdy_mode = 2;
      for (int k = 0; k < n; k++) begin
        t = (base + k) % 64;
        if ($urandom_range(0, 3) == 0) drop(t, 1);
        else tg.push_back(t);
      end
      for (int k = tg.size() - 1; k > 0; k--) begin
        j = $urandom_range(0, k);
        tmp = tg[k];
        tg[k] = tg[j];
        tg[j] = tmp;
      end
      target = mon_pkts + tg.size();
      foreach (tg[k]) send_pkt(tg[k], $urandom_range(0, 7) == 0 ? 40 : $urandom_range(1, 12), 1);
      wait_pkts(target);
      repeat (12) step();
      settle();
      chk("rnd_exp", expected_tag, mexp);
    end
    chk("rnd_npk", num_packets_out, 16'(mon_pkts));
    chk("rnd_ov", ov_n, 1);
    chk("rnd_dc", dc_n, 1);

    rdy_mode = 1;
    settle();
    send_pkt(mexp, 40, 0);
    for (int k = 0; k < 200 && cur.size() < 5; k++) step();
    chk("p6_midsend", out_TVALID, 1);
    rst = 1;
    #1;
    chk("p6_tvalid", out_TVALID, 0);
    chk("p6_exp", expected_tag, 0);
    chk("p6_npk", num_packets_out, 0);
    chk("p6_tready", cb_TREADY, 0);
    for (int k = 0; k < 64; k++) begin
      mq[k].delete();
      lenq[k].delete();
      dropped[k] = 0;
    end
    mexp = 0;
    step();
    step();
    rst = 0;
    step();
    chk("p6_tready1", cb_TREADY, 1);
    pk_base = mon_pkts;
    send_pkt(0, 4, 0);
    wait_pkts(pk_base + 1);
    step();
    chk("p6_exp1", expected_tag, 1);
    chk("p6_npk1", num_packets_out, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
